// File: rtl/tcdm_store_streamer_if.sv
// Ready/valid beat stream carrying data and byte strobes (FIFO pop side).
// The sink modport is used by tcdm_store_streamer.
interface stream_intf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = (DATA_WIDTH + 7) / 8
) ();
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;
  logic                  valid;
  logic                  ready;

  modport source (output data, output strb, output valid, input ready);
  modport sink   (input data, input strb, input valid, output ready);
endinterface

// File: rtl/tcdm_store_streamer.sv
// Drains a FIFO pop stream into TCDM write requests with a base/stride/length address generator.
// Optional TCDM_STREAMER_STRB_SKIP_EN: all-zero-strobe beats are consumed without a TCDM request.
module tcdm_store_streamer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned BE_WIDTH   = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [CNT_WIDTH-1:0]  length_i,
  output logic                  busy_o,
  output logic                  done_o,
  stream_intf.sink              stream_i,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [DATA_WIDTH-1:0] tcdm_data_o,
  output logic [BE_WIDTH-1:0]   tcdm_be_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic in_run;
  logic handshake;
  logic last_beat;

  assign in_run    = (state_q == RUN);
  assign last_beat = (cnt_q == len_q - CNT_WIDTH'(1));

`ifdef TCDM_STREAMER_STRB_SKIP_EN
  logic strb_zero;
  assign strb_zero = (stream_i.strb == '0);

  // A zero-strobe beat completes on valid alone and never reaches the TCDM.
  assign tcdm_req_o     = in_run & stream_i.valid & ~strb_zero;
  assign stream_i.ready = in_run & (tcdm_gnt_i | (stream_i.valid & strb_zero));
  assign handshake      = in_run & stream_i.valid & (tcdm_gnt_i | strb_zero);
`else
  assign tcdm_req_o     = in_run & stream_i.valid;
  assign stream_i.ready = in_run & tcdm_gnt_i;
  assign handshake      = in_run & stream_i.valid & tcdm_gnt_i;
`endif

  assign tcdm_add_o  = addr_q;
  assign tcdm_wen_o  = 1'b0;
  assign tcdm_data_o = tcdm_req_o ? stream_i.data : '0;
  assign tcdm_be_o   = tcdm_req_o ? stream_i.strb : '0;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (length_i != '0) begin
            state_d  = RUN;
            addr_d   = base_addr_i;
            stride_d = stride_i;
            len_d    = length_i;
            cnt_d    = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (handshake) begin
          addr_d = addr_q + stride_q;
          cnt_d  = cnt_q + CNT_WIDTH'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset and soft clear are both synchronous and identical.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tcdm_store_streamer.sv
// Directed self-checking bench for tcdm_store_streamer; a queue stands in for the upstream FIFO.
module tb_tcdm_store_streamer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] stride_i;
  logic [CW-1:0] length_i;
  logic          busy_o;
  logic          done_o;
  logic          tcdm_req_o;
  logic          tcdm_gnt_i;
  logic [AW-1:0] tcdm_add_o;
  logic          tcdm_wen_o;
  logic [DW-1:0] tcdm_data_o;
  logic [3:0]    tcdm_be_o;

  stream_intf #(.DATA_WIDTH(DW)) s_if ();

  tcdm_store_streamer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .stride_i   (stride_i),
    .length_i   (length_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .stream_i   (s_if),
    .tcdm_req_o (tcdm_req_o),
    .tcdm_gnt_i (tcdm_gnt_i),
    .tcdm_add_o (tcdm_add_o),
    .tcdm_wen_o (tcdm_wen_o),
    .tcdm_data_o(tcdm_data_o),
    .tcdm_be_o  (tcdm_be_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] req_add[$];
  logic [31:0] req_data[$];
  logic [3:0]  req_be[$];
  int          req_cyc[$];
  logic [31:0] hs_add[$];
  logic [31:0] hs_data[$];
  int          hs_cyc[$];
  int          done_cnt;
  int          done_cyc;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] s);
    beat_t b;
    b.data = d;
    b.strb = s;
    beat_q.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after acceptance.
  task automatic launch(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] len);
    start_i     = 1'b1;
    base_addr_i = base;
    stride_i    = stride;
    length_i    = len;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Cycle c = 0 is the first cycle after start acceptance; returns after DONE or after a clear.
  task automatic run_xfer(input logic [7:0] gnt_pat, input int pat_len,
                          input int mid_start, input int abort_after);
    logic [31:0] prev_add;
    logic [31:0] prev_data;
    logic        prev_stall;
    logic        fired;
    logic        finished;
    prev_stall = 1'b0;
    prev_add   = '0;
    prev_data  = '0;
    finished   = 1'b0;
    req_add.delete(); req_data.delete(); req_be.delete(); req_cyc.delete();
    hs_add.delete(); hs_data.delete(); hs_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 0; c < 60; c++) begin
      tcdm_gnt_i = gnt_pat[c % pat_len];
      if (abort_after >= 0 && hs_add.size() == abort_after) begin
        clear_i    = 1'b1;
        tcdm_gnt_i = 1'b0;
      end
      if (beat_q.size() > 0) begin
        s_if.valid = 1'b1;
        s_if.data  = beat_q[0].data;
        s_if.strb  = beat_q[0].strb;
      end else begin
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.strb  = '0;
      end
      if (c == mid_start) begin
        start_i     = 1'b1;
        base_addr_i = 32'hDEAD_0000;
        stride_i    = 32'h100;
        length_i    = 16'd7;
      end
      #1;
      if (prev_stall) begin
        check("stall_req", tcdm_req_o, 1'b1);
        check("stall_add", tcdm_add_o, prev_add);
        check("stall_data", tcdm_data_o, prev_data);
      end
      prev_stall = tcdm_req_o & ~tcdm_gnt_i;
      prev_add   = tcdm_add_o;
      prev_data  = tcdm_data_o;
      if (tcdm_req_o) begin
        req_add.push_back(tcdm_add_o);
        req_data.push_back(tcdm_data_o);
        req_be.push_back(tcdm_be_o);
        req_cyc.push_back(c);
      end
      fired = s_if.valid & s_if.ready;
      if (fired) begin
        hs_add.push_back(tcdm_add_o);
        hs_data.push_back(s_if.data);
        hs_cyc.push_back(c);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = c;
      end
      @(posedge clk);
      #1;
      if (fired) void'(beat_q.pop_front());
      start_i = 1'b0;
      if (clear_i) begin
        clear_i = 1'b0;
        finished = 1'b1;
        break;
      end
      if (done_cyc >= 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) check("xfer_timeout", finished, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_req"}, tcdm_req_o, 1'b0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    stride_i    = '0;
    length_i    = '0;
    tcdm_gnt_i  = 1'b1;
    s_if.valid  = 1'b1;
    s_if.data   = 32'h1234_5678;
    s_if.strb   = 4'hF;

    // Reset with a beat pending and grant high: nothing may leak out.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", tcdm_req_o, 1'b0);
    check("rst_add", tcdm_add_o, 32'h0);
    check("rst_data", tcdm_data_o, 32'h0);
    check("rst_be", tcdm_be_o, 4'h0);
    check("rst_wen", tcdm_wen_o, 1'b0);
    check("rst_ready", s_if.ready, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", s_if.ready, 1'b0);
    check_idle("idle");
    s_if.valid = 1'b0;

    // Basic run, grant always high.
    for (int i = 0; i < 4; i++) push_beat(32'hD000_0000 + i, 4'hF);
    launch(32'h1000, 32'h4, 16'd4);
    check("basic_busy", busy_o, 1'b1);
    run_xfer(8'hFF, 1, -1, -1);
    check("basic_nreq", req_add.size(), 4);
    for (int i = 0; i < 4 && i < req_add.size(); i++) begin
      check("basic_add", req_add[i], 32'h1000 + 4 * i);
      check("basic_data", req_data[i], 32'hD000_0000 + i);
      check("basic_be", req_be[i], 4'hF);
      check("basic_cyc", req_cyc[i], i);
    end
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_cyc", done_cyc, 4);
    check_idle("basic_end");

    // Grant backpressure 1,0,0 repeating.
    for (int i = 0; i < 3; i++) push_beat(32'hB000_0000 + i, 4'h3);
    launch(32'h2000, 32'h8, 16'd3);
    run_xfer(8'b0000_0001, 3, -1, -1);
    check("bp_nhs", hs_add.size(), 3);
    for (int i = 0; i < 3 && i < hs_add.size(); i++) begin
      check("bp_add", hs_add[i], 32'h2000 + 8 * i);
      check("bp_data", hs_data[i], 32'hB000_0000 + i);
      check("bp_cyc", hs_cyc[i], 3 * i);
    end
    check("bp_done_cyc", done_cyc, 7);
    check("bp_done_cnt", done_cnt, 1);

    // Negative stride wrapping below zero.
    for (int i = 0; i < 4; i++) push_beat(32'hC000_0000 + i, 4'hF);
    launch(32'h8, 32'hFFFF_FFFC, 16'd4);
    run_xfer(8'hFF, 1, -1, -1);
    check("neg_nhs", hs_add.size(), 4);
    if (hs_add.size() == 4) begin
      check("neg_add0", hs_add[0], 32'h8);
      check("neg_add1", hs_add[1], 32'h4);
      check("neg_add2", hs_add[2], 32'h0);
      check("neg_add3", hs_add[3], 32'hFFFF_FFFC);
    end

    // Positive stride crossing the top of the address space.
    for (int i = 0; i < 4; i++) push_beat(32'hE000_0000 + i, 4'hF);
    launch(32'hFFFF_FFF8, 32'h4, 16'd4);
    run_xfer(8'hFF, 1, -1, -1);
    check("up_nhs", hs_add.size(), 4);
    if (hs_add.size() == 4) begin
      check("up_add0", hs_add[0], 32'hFFFF_FFF8);
      check("up_add1", hs_add[1], 32'hFFFF_FFFC);
      check("up_add2", hs_add[2], 32'h0);
      check("up_add3", hs_add[3], 32'h4);
    end
    check("up_done_cnt", done_cnt, 1);

    // Zero length: done next cycle, no request even with a beat offered.
    s_if.valid = 1'b1;
    s_if.data  = 32'hFACE_0000;
    s_if.strb  = 4'hF;
    tcdm_gnt_i = 1'b1;
    launch(32'h7000, 32'h4, 16'd0);
    check("zero_done", done_o, 1'b1);
    check("zero_busy", busy_o, 1'b1);
    check("zero_req", tcdm_req_o, 1'b0);
    check("zero_ready", s_if.ready, 1'b0);
    @(posedge clk);
    #1;
    check_idle("zero_end");
    s_if.valid = 1'b0;

    // Start pulse mid-transfer must be ignored.
    for (int i = 0; i < 3; i++) push_beat(32'h5500_0000 + i, 4'hF);
    launch(32'h3000, 32'h10, 16'd3);
    run_xfer(8'b0000_0001, 2, 1, -1);
    check("midst_nhs", hs_add.size(), 3);
    for (int i = 0; i < 3 && i < hs_add.size(); i++)
      check("midst_add", hs_add[i], 32'h3000 + 16 * i);
    check("midst_done_cnt", done_cnt, 1);
    check_idle("midst_end");

    // Abort after 2 of 8 beats, then a fresh start at a new base.
    for (int i = 0; i < 8; i++) push_beat(32'hAB00_0000 + i, 4'hF);
    launch(32'h4000, 32'h4, 16'd8);
    run_xfer(8'hFF, 1, -1, 2);
    check("abort_nhs", hs_add.size(), 2);
    check("abort_done_cnt", done_cnt, 0);
    check_idle("abort_idle");
    check("abort_add", tcdm_add_o, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("abort_nodone", done_o, 1'b0);
    end
    beat_q.delete();
    for (int i = 0; i < 2; i++) push_beat(32'h6600_0000 + i, 4'hF);
    launch(32'h5000, 32'h4, 16'd2);
    run_xfer(8'hFF, 1, -1, -1);
    check("restart_nhs", hs_add.size(), 2);
    if (hs_add.size() == 2) begin
      check("restart_add0", hs_add[0], 32'h5000);
      check("restart_add1", hs_add[1], 32'h5004);
      check("restart_data1", hs_data[1], 32'h6600_0001);
    end
    check("restart_done_cnt", done_cnt, 1);

    // Zero-strobe beat in the middle.
    push_beat(32'h7700_0000, 4'hF);
    push_beat(32'h7700_0001, 4'h0);
    push_beat(32'h7700_0002, 4'hF);
    launch(32'h6000, 32'h4, 16'd3);
    run_xfer(8'hFF, 1, -1, -1);
    check("strb_nhs", hs_add.size(), 3);
`ifdef TCDM_STREAMER_STRB_SKIP_EN
    check("strb_nreq", req_add.size(), 2);
    if (req_add.size() == 2) begin
      check("strb_add0", req_add[0], 32'h6000);
      check("strb_add1", req_add[1], 32'h6008);
      check("strb_data1", req_data[1], 32'h7700_0002);
    end
`else
    check("strb_nreq", req_add.size(), 3);
    if (req_add.size() == 3) begin
      check("strb_add1", req_add[1], 32'h6004);
      check("strb_be1", req_be[1], 4'h0);
      check("strb_add2", req_add[2], 32'h6008);
      check("strb_be2", req_be[2], 4'hF);
    end
`endif
    check("strb_done_cnt", done_cnt, 1);
    check_idle("strb_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcdm_store_streamer.md
# tcdm_store_streamer

Sink stage placed directly downstream of the stream FIFO. It consumes the FIFO's pop stream (`data`/`strb`/`valid`/`ready`) and turns every accepted beat into a TCDM write request, using an address generator programmed with base, stride and beat count. It reports `busy_o` while a transfer is in flight and pulses `done_o` when the transfer completes; the FIFO decouples it from the producer.

## Interface
- `DATA_WIDTH`, default 32: stream and TCDM data width; byte-enable width is `(DATA_WIDTH+7)/8`.
- `ADDR_WIDTH`, default 32: TCDM address width.
- `CNT_WIDTH`, default 16: width of the transfer length and beat counter.

- `clk_i`, input, 1: single clock, all logic rising-edge.
- `rst_ni`, input, 1: reset, synchronous, active-low.
- `clear_i`, input, 1: synchronous soft clear, same effect as reset.
- `start_i`, input, 1: launch request, sampled in IDLE only.
- `base_addr_i`, input, ADDR_WIDTH: first write address.
- `stride_i`, input, ADDR_WIDTH: two's-complement address increment per beat.
- `length_i`, input, CNT_WIDTH: number of beats in the transfer.
- `busy_o`, output, 1: high in RUN and DONE.
- `done_o`, output, 1: one-cycle completion pulse.
- `stream_i`, `stream_intf.sink`, DATA_WIDTH: input beats from the FIFO `pop_o`.
- `tcdm_req_o`, output, 1: request valid.
- `tcdm_gnt_i`, input, 1: grant.
- `tcdm_add_o`, output, ADDR_WIDTH: byte address.
- `tcdm_wen_o`, output, 1: constant 0 (write).
- `tcdm_data_o`, output, DATA_WIDTH: write data, equal to `stream_i.data`.
- `tcdm_be_o`, output, (DATA_WIDTH+7)/8: byte enables, equal to `stream_i.strb`.

## Operation
- FSM states and transitions:
  - IDLE to RUN on `start_i` when `length_i != 0`. This latches the base address into `addr_q`, latches stride and length, and sets `cnt_q = 0`.
  - IDLE to DONE on `start_i` when `length_i == 0`.
  - RUN to DONE on a handshake when `cnt_q == len_q-1`.
  - DONE to IDLE unconditionally after one cycle.
- In RUN, the stream and TCDM are combinationally coupled:
  - `tcdm_req_o = stream_i.valid`
  - `stream_i.ready = tcdm_gnt_i`
  - `tcdm_add_o = addr_q`
- A handshake is `stream_i.valid & tcdm_gnt_i`. On a handshake:
  - `addr_q <= addr_q + stride_q`, truncated to ADDR_WIDTH so it wraps modulo 2^ADDR_WIDTH.
  - `cnt_q <= cnt_q + 1`.
- In IDLE and DONE, `tcdm_req_o = 0` and `stream_i.ready = 0`. Beats stay in the FIFO.
- `start_i` is ignored in RUN and DONE; parameters cannot be changed mid-transfer.
- `tcdm_gnt_i` without `stream_i.valid` has no effect.
- `clear_i` or reset in any state forces IDLE and zeroes `addr_q`, `cnt_q`, `len_q` and `stride_q`. No `done_o` is generated for the aborted transfer.
- Reset values: `tcdm_req_o=0`, `tcdm_add_o=0`, `tcdm_data_o=0`, `tcdm_be_o=0`, `tcdm_wen_o=0`, `stream_i.ready=0`, `busy_o=0`, `done_o=0`.
- `tcdm_data_o` and `tcdm_be_o` are forced to 0 whenever `tcdm_req_o=0`.

## Timing
- `start_i` accepted in cycle N gives the first possible request in cycle N+1.
- Valid-to-request and grant-to-ready paths are zero-latency (combinational).
- Throughput is 1 beat/cycle under continuous valid and grant.
- `done_o` is high in the cycle after the last handshake; IDLE is entered the following cycle.
- Minimum back-to-back spacing: a new `start_i` is accepted at the earliest two cycles after the last handshake.
- A zero-length start gives `done_o` in cycle N+1 with no requests.
- A stalled grant holds `tcdm_add_o`, `tcdm_data_o` and `tcdm_be_o` stable while `tcdm_req_o` stays high. The FIFO keeps its pop data stable until `ready` is asserted.

## Configuration
- `TCDM_STREAMER_STRB_SKIP_EN` defined: a RUN beat with `strb == 0` is consumed without a TCDM request.
  - `tcdm_req_o=0` and `stream_i.ready=1` for that beat.
  - The handshake is `valid` alone; the address still advances and the count still increments.
- `TCDM_STREAMER_STRB_SKIP_EN` undefined: all-zero-strobe beats are issued as requests with `tcdm_be_o=0` and wait for a grant like any other beat.

## Test plan
- Basic run, grant always 1: base 0x1000, stride 4, length 4, beats D0..D3 with strb 0xF.
  - Requests at 0x1000, 0x1004, 0x1008, 0x100C in four consecutive cycles.
  - `done_o` pulses once.
- Grant backpressure, grant toggling 1,0,0,1,...: address and data held stable while `gnt=0`, no beat lost or duplicated, 3 beats total.
- Negative stride and wrap:
  - base 0x8, stride 0xFFFFFFFC, length 4 gives addresses 0x8, 0x4, 0x0, 0xFFFFFFFC.
  - A second case crosses the top of the address space upward without overflow side effects.
- Zero length and start in RUN:
  - `length_i=0` gives `done_o` in the next cycle with no requests.
  - `start_i` asserted mid-transfer with other parameters leaves the addresses unchanged.
- Abort: `clear_i` after 2 of 8 beats gives IDLE next cycle, `busy_o=0`, no `done_o`; a fresh start restarts at the new base.
- Strb zero beat, length 3, strbs 0xF, 0x0, 0xF:
  - With `TCDM_STREAMER_STRB_SKIP_EN`: 2 requests, at base and base+2*stride.
  - Without it: 3 requests, the middle one with `be=0`.
